// File: rtl/ro_phase_quantizer.sv
// Purpose : measures how far the ring oscillator phase advances over a window of
//           win_len clk cycles, in units of one stage delay.
// Latency : accepted start at cycle 0 -> code_valid at cycle W+4 (W = max(win_len,1)).
// Backpr. : code/ovf/code_valid are held in DONE until code_ready; no new start is
//           taken until the result has been accepted and the FSM is back in IDLE.
//
// Ports:
//   clk, rst_n          single clock, asynchronous active-low reset
//   ro_tap[N_PHASE]     asynchronous ring taps, bit i = vop of stage i
//   start, win_len      measurement request and window length (sampled on start)
//   busy                high whenever a measurement is in progress or pending
//   code, ovf           phase advance and saturation flag, qualified by code_valid
//   code_valid/ready    result handshake
module ro_phase_quantizer #(
    parameter int N_PHASE = 5,
    parameter int CNT_W   = 12,
    parameter int WIN_W   = 16,
    parameter int CODE_W  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_PHASE-1:0]  ro_tap,
    input  logic                start,
    input  logic [WIN_W-1:0]    win_len,
    output logic                busy,
    output logic [CODE_W-1:0]   code,
    output logic                code_valid,
    input  logic                code_ready,
    output logic                ovf
);

    // Fine phase width: holds 0..2*N_PHASE-1 (and the popcount 0..N_PHASE).
    localparam int PW     = $clog2(2 * N_PHASE);
    // Wrap count times phases-per-wrap never exceeds this width.
    localparam int PROD_W = CNT_W + PW;
    // Signed working width for the result. It is at least CODE_W+2 and is widened
    // further when a saturated wrap count could otherwise alias into range.
    localparam int TOT_W  = ((CODE_W > PROD_W) ? CODE_W : PROD_W) + 2;

    localparam logic [CNT_W-1:0]        WRAP_MAX = '1;
    localparam logic signed [TOT_W-1:0] CODE_MAX = TOT_W'({CODE_W{1'b1}});

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM1,
        S_ARM2,
        S_COUNT,
        S_CALC,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    // ------------------------------------------------------------------
    // Tap synchronizers. msb_d is the previous synchronized MSB, used to
    // spot the 2N-1 -> 0 wrap as a falling edge of the last tap.
    // ------------------------------------------------------------------
    logic [N_PHASE-1:0] sync1;
    logic [N_PHASE-1:0] s_tap;
    logic               msb_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            s_tap <= '0;
            msb_d <= 1'b0;
        end else begin
            sync1 <= ro_tap;
            s_tap <= sync1;
            msb_d <= s_tap[N_PHASE-1];
        end
    end

    logic wrap_det;
    assign wrap_det = msb_d & ~s_tap[N_PHASE-1];

    // ------------------------------------------------------------------
    // Fine decode. A Johnson ring fills with ones from tap 0 upward during
    // the first half period and empties from tap 0 upward in the second;
    // the last tap tells the two halves apart. Bubbles simply fall through
    // the popcount.
    // ------------------------------------------------------------------
    logic [PW-1:0] ones;
    logic [PW-1:0] p;

    always_comb begin
        ones = '0;
        for (int i = 0; i < N_PHASE; i++) begin
            ones = ones + PW'(s_tap[i]);
        end
        if (s_tap[N_PHASE-1]) begin
            p = PW'(2 * N_PHASE) - ones;
        end else begin
            p = ones;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers.
    // ------------------------------------------------------------------
    logic [WIN_W-1:0] rem;       // COUNT cycles still to go after the current one
    logic [CNT_W-1:0] wraps;
    logic             ovf_i;     // wrap counter hit its ceiling
    logic [PW-1:0]    p_start;
    logic [PW-1:0]    p_end;

    // FSM control strobes
    logic ld_win;
    logic cap_start;
    logic cnt_en;
    logic last_cnt;
    logic do_calc;
    logic accept;

    assign last_cnt = cnt_en && (rem == '0);

    // ------------------------------------------------------------------
    // FSM: state register + next-state/strobe decode.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ld_win    = 1'b0;
        cap_start = 1'b0;
        cnt_en    = 1'b0;
        do_calc   = 1'b0;
        accept    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ld_win  = 1'b1;
                    state_d = S_ARM1;
                end
            end
            // Two ARM cycles let the synchronizers flush stale tap values.
            S_ARM1: begin
                state_d = S_ARM2;
            end
            S_ARM2: begin
                cap_start = 1'b1;
                state_d   = S_COUNT;
            end
            S_COUNT: begin
                cnt_en = 1'b1;
                if (rem == '0) begin
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                do_calc = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (code_ready) begin
                    accept  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy = (state_q != S_IDLE);

    // ------------------------------------------------------------------
    // Result arithmetic: whole wraps plus the fine-phase difference.
    // ------------------------------------------------------------------
    logic [PROD_W-1:0]       wrap_ph;
    logic signed [TOT_W-1:0] total;
    logic [CODE_W-1:0]       code_d;
    logic                    sat_d;

    assign wrap_ph = PROD_W'(wraps) * PROD_W'(2 * N_PHASE);
    assign total   = $signed(TOT_W'(wrap_ph)) + $signed(TOT_W'(p_end))
                   - $signed(TOT_W'(p_start));

    always_comb begin
        code_d = '0;
        sat_d  = 1'b0;
        if (total[TOT_W-1]) begin
            // Negative only for bubbled taps or an undersampled ring.
            code_d = '0;
        end else if (total > CODE_MAX) begin
            code_d = '1;
            sat_d  = 1'b1;
        end else begin
            code_d = total[CODE_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem        <= '0;
            wraps      <= '0;
            ovf_i      <= 1'b0;
            p_start    <= '0;
            p_end      <= '0;
            code       <= '0;
            ovf        <= 1'b0;
            code_valid <= 1'b0;
        end else begin
            // A zero window is run as a one-cycle window.
            if (ld_win) begin
                rem <= (win_len == '0) ? '0 : (win_len - 1'b1);
            end

            if (cap_start) begin
                p_start <= p;
                wraps   <= '0;
                ovf_i   <= 1'b0;
            end

            if (cnt_en) begin
                if (rem != '0) begin
                    rem <= rem - 1'b1;
                end
                if (wrap_det && (wraps != WRAP_MAX)) begin
                    wraps <= wraps + 1'b1;
                    if (wraps == (WRAP_MAX - 1'b1)) begin
                        ovf_i <= 1'b1;
                    end
                end
            end

            // The wrap seen in this same cycle lands in wraps together with p_end.
            if (last_cnt) begin
                p_end <= p;
            end

            if (do_calc) begin
                code       <= code_d;
                ovf        <= sat_d | ovf_i;
                code_valid <= 1'b1;
            end else if (accept) begin
                code_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ro_phase_quantizer.sv
// Purpose : bench for ro_phase_quantizer; a stepping Johnson ring drives two
//           instances (CODE_W=16 and CODE_W=6) and results are compared with
//           the true phase advance of the ring over the window.
// Latency : one measurement per W+4 cycles plus handshake.
// Backpr. : code_ready is withheld for a chosen number of cycles per result.
module tb_ro_phase_quantizer;

    localparam int NP = 5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [NP-1:0] ro_tap = '0;
    logic        start;
    logic [15:0] win_len;
    logic        code_ready;

    logic        busy, code_valid, ovf;
    logic [15:0] code;
    logic        busy6, cv6, ovf6;
    logic [5:0]  code6;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ro_phase_quantizer dut (
        .clk(clk), .rst_n(rst_n), .ro_tap(ro_tap), .start(start), .win_len(win_len),
        .busy(busy), .code(code), .code_valid(code_valid), .code_ready(code_ready), .ovf(ovf)
    );

    ro_phase_quantizer #(.CODE_W(6)) dut6 (
        .clk(clk), .rst_n(rst_n), .ro_tap(ro_tap), .start(start), .win_len(win_len),
        .busy(busy6), .code(code6), .code_valid(cv6), .code_ready(code_ready), .ovf(ovf6)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // ---------------- ring model: absolute phase, steps every ring_per cycles
    int ring_per = 0;
    int load_ph  = 0;
    int load_seq = 0;
    int absph    = 0;
    int tick     = 0;
    int seen_seq = 0;

    function automatic logic [NP-1:0] johnson(input int ph);
        int q;
        q = ph % (2 * NP);
        if (q <= NP) return NP'((1 << q) - 1);
        return NP'(((1 << NP) - 1) & ~((1 << (q - NP)) - 1));
    endfunction

    always @(negedge clk) begin
        if (load_seq != seen_seq) begin
            seen_seq = load_seq;
            absph    = load_ph;
            tick     = 0;
        end else if (ring_per > 0) begin
            tick++;
            if (tick >= ring_per) begin
                tick = 0;
                absph++;
            end
        end
        ro_tap = johnson(absph);
    end

    task automatic set_ring(input int per, input int ph);
        ring_per = per;
        load_ph  = ph;
        load_seq++;
        repeat (3) @(negedge clk);
    endtask

    // ---------------- one full measurement with handshake
    task automatic measure(input int w, input int bp, input bit start_in_accept);
        int wq, lat, ph0, ph1, d;
        int e16, e6;
        logic [15:0] hold;
        wq  = (w == 0) ? 1 : w;
        lat = 0;
        ph1 = 0;
        @(negedge clk);
        start   = 1'b1;
        win_len = w[15:0];
        @(posedge clk);
        ph0 = absph;
        #1;
        start   = 1'b0;
        win_len = 16'($urandom);
        chk("busy_after_start", busy, 1);
        for (int k = 1; k <= wq + 20; k++) begin
            @(posedge clk);
            if (k == wq) ph1 = absph;
            #1;
            if (code_valid) begin
                lat = k + 1;
                break;
            end
        end
        chk("latency", lat, wq + 4);
        chk("cv6", cv6, 1);

        d   = ph1 - ph0;
        e16 = (d < 0) ? 0 : ((d > 65535) ? 65535 : d);
        e6  = (d < 0) ? 0 : ((d > 63) ? 63 : d);
        chk("code", code, e16);
        chk("ovf", ovf, (d > 65535) ? 1 : 0);
        chk("code6", code6, e6);
        chk("ovf6", ovf6, (d > 63) ? 1 : 0);
        hold = code;

        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            start = (i == 0);
            @(posedge clk);
            #1;
            chk("bp_code_stable", code, hold);
            chk("bp_valid_held", code_valid, 1);
            chk("bp_busy", busy, 1);
        end

        @(negedge clk);
        code_ready = 1'b1;
        start      = start_in_accept;
        @(posedge clk);
        #1;
        code_ready = 1'b0;
        start      = 1'b0;
        chk("valid_clear", code_valid, 0);
        chk("busy_clear", busy, 0);
        chk("code_kept", code, hold);
        @(posedge clk);
        #1;
        chk("idle_after_accept", busy, 0);
    endtask

    initial begin
        int bad;
        rst_n      = 1'b0;
        start      = 1'b0;
        code_ready = 1'b0;
        win_len    = '0;

        repeat (3) begin
            @(negedge clk);
            chk("rst_busy", busy, 0);
            chk("rst_valid", code_valid, 0);
            chk("rst_code", code, 0);
            chk("rst_ovf", ovf, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            chk("idle_busy", busy, 0);
            chk("idle_valid", code_valid, 0);
            chk("idle_code", code, 0);
            chk("idle_ovf", ovf, 0);
        end

        // static ring at p=3
        set_ring(0, 3);
        measure(50, 3, 0);
        // one wrap in 40 cycles
        set_ring(4, 0);
        measure(40, 0, 0);
        // two wraps plus three stages, start in the acceptance cycle
        set_ring(4, 0);
        measure(92, 2, 1);
        // 100 stages: saturates the 6-bit instance only
        set_ring(3, 0);
        measure(300, 1, 0);
        // zero window runs as one cycle
        set_ring(3, 7);
        measure(0, 0, 0);
        // long backpressure with a start issued in DONE
        set_ring(5, 2);
        measure(60, 30, 1);

        for (int r = 0; r < 8; r++) begin
            set_ring($urandom_range(3, 8), $urandom_range(0, 50));
            measure($urandom_range(0, 150), $urandom_range(0, 4), 1'($urandom_range(0, 1)));
        end

        // reset in the middle of COUNT
        set_ring(4, 0);
        @(negedge clk);
        start   = 1'b1;
        win_len = 16'd100;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_valid", code_valid, 0);
        chk("mid_rst_code", code, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 130; i++) begin
            @(posedge clk);
            #1;
            if (code_valid || busy) bad++;
        end
        chk("no_result_after_reset", bad, 0);

        set_ring(6, 4);
        measure(30, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
